uart_frame_ctrl: RTL

Frame sequencer behind the UART byte receiver. Consumes the receiver's byte stream and parses it as a command byte followed by NUM_BYTES payload bytes. Assembles the payload into one wide word and hands it to the RSA datapath over a valid/ready handshake. Also detects inter-byte timeouts and bytes that arrive while a word is still pending.

---
 rtl/uart_frame_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: frame sequencer behind the UART byte receiver.
// A frame is one command byte followed by NUM_BYTES payload bytes. The
// payload is packed little-endian into a wide word and offered to the
// datapath over a valid/ready handshake.
// Optional inter-byte timeout logic is built when UART_FRAME_TIMEOUT_EN is
// defined; otherwise DATA waits indefinitely and err_timeout is tied low.
module uart_frame_ctrl #(
  parameter int NUM_BYTES     = 8,
  parameter int TIMEOUT_TICKS = 1760
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   baud_tick,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic [7:0]             cmd,
  output logic [8*NUM_BYTES-1:0] word,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   busy,
  output logic                   err_timeout,
  output logic                   err_overrun
);

  localparam int W     = 8 * NUM_BYTES;
  localparam int CNT_W = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rx_valid_q;
  logic             byte_evt;
  logic             last_byte;
  logic             start_frame;
  logic             timeout_hit;
  logic [CNT_W-1:0] byte_cnt;
  logic [W+7:0]     word_cat;

  // rx_valid is a level that may last many cycles; only its rising edge counts
  assign byte_evt  = rx_valid & ~rx_valid_q;
  assign last_byte = (byte_cnt == CNT_W'(NUM_BYTES - 1));

  // A new frame begins from IDLE, or straight out of HOLD when the pending
  // word is accepted in the same cycle the next command byte arrives
  assign start_frame = byte_evt & ((state == IDLE) | ((state == HOLD) & word_ready));

  // New byte enters at the top so the first payload byte ends up in word[7:0]
  assign word_cat = {rx_data, word};

  // Delayed copy of rx_valid for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_valid_q <= 1'b0;
    else        rx_valid_q <= rx_valid;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a byte arriving on the terminal tick beats the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (byte_evt) state_nxt = DATA;
      DATA: begin
        if (byte_evt && last_byte) state_nxt = HOLD;
        else if (timeout_hit)      state_nxt = IDLE;
      end
      HOLD: if (word_ready) state_nxt = byte_evt ? DATA : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state
  always_comb begin
    word_valid = (state == HOLD);
    busy       = (state != IDLE);
  end

  // Command, payload shift register and byte counter; word and cmd hold
  // their last value after a handshake or abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= 8'h00;
      word     <= '0;
      byte_cnt <= '0;
    end else if (start_frame) begin
      cmd      <= rx_data;
      byte_cnt <= '0;
    end else if ((state == DATA) && byte_evt) begin
      word     <= word_cat[W+7:8];
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  // Byte dropped because the previous word is still waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_overrun <= 1'b0;
    else        err_overrun <= (state == HOLD) & byte_evt & ~word_ready;
  end

`ifdef UART_FRAME_TIMEOUT_EN
  logic [10:0] tmo_cnt;

  assign timeout_hit = (state == DATA) & baud_tick & ~byte_evt &
                       (tmo_cnt == 11'(TIMEOUT_TICKS - 1));

  // Ticks since the last byte; only meaningful while collecting payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               tmo_cnt <= '0;
    else if ((state != DATA) || byte_evt)     tmo_cnt <= '0;
    else if (timeout_hit)                     tmo_cnt <= '0;
    else if (baud_tick)                       tmo_cnt <= tmo_cnt + 11'd1;
  end

  // One-cycle abort indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_timeout <= 1'b0;
    else        err_timeout <= timeout_hit;
  end
`else
  logic unused_tick;

  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
  // baud_tick and TIMEOUT_TICKS have no consumer in this build
  assign unused_tick = baud_tick ^ (TIMEOUT_TICKS == 0);
`endif

endmodule
